// File: rtl/fpnew_pkg.sv
// Shared FP types: IEEE status flags and the lane-count helper used by the cast packer.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned num_lanes(input int unsigned width, input int unsigned lane_width);
    return width / lane_width;
  endfunction

endpackage

// File: rtl/fpnew_cast_packer.sv
// Packs scalar cast results into a NaN-boxed SIMD word; word valid the cycle after its closing lane.
// Backpressure: in_ready_o falls in HOLD unless out_ready_i; FPNEW_PACKER_LANE_STATUS_EN adds lane_status_o.
module fpnew_cast_packer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned DstWidth = 16,
  parameter type         TagType  = logic,
  localparam int unsigned NumLanes = num_lanes(Width, DstWidth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DstWidth-1:0] result_i,
  input  status_t             status_i,
  input  logic                extension_bit_i,
  input  TagType              tag_i,
  input  logic                last_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [Width-1:0]    result_o,
  output status_t             status_o,
  output logic                extension_bit_o,
  output TagType              tag_o,
  output logic [NumLanes-1:0] lane_mask_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
`ifdef FPNEW_PACKER_LANE_STATUS_EN
  output status_t [NumLanes-1:0] lane_status_o,
`endif
  output logic                busy_o
);

  if ((Width % DstWidth) != 0 || NumLanes == 0) begin : g_bad_width
    $error("fpnew_cast_packer: Width must be a non-zero multiple of DstWidth");
  end

  localparam int unsigned CntW = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(NumLanes - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [Width-1:0]    result_q, result_d;
  status_t             status_q, status_d;
  logic                ext_q, ext_d;
  TagType              tag_q, tag_d;
  logic [NumLanes-1:0] mask_q, mask_d;
  logic [CntW-1:0]     lane_idx;
  logic                in_accept;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
  status_t [NumLanes-1:0] lane_status_q, lane_status_d;
`endif

  assign in_ready_o = (state_q == FILL) | ((state_q == HOLD) & out_ready_i);
  assign in_accept  = in_valid_i & in_ready_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    status_d = status_q;
    ext_d    = ext_q;
    tag_d    = tag_q;
    mask_d   = mask_q;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
    lane_status_d = lane_status_q;
`endif
    // A lane accepted while the previous word departs opens the next word at lane 0.
    lane_idx = (state_q == HOLD) ? '0 : cnt_q;

    if (flush_i) begin
      state_d  = FILL;
      cnt_d    = '0;
      result_d = '1;
      status_d = '0;
      ext_d    = 1'b1;
      tag_d    = '0;
      mask_d   = '0;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
      lane_status_d = '0;
`endif
    end else begin
      if ((state_q == HOLD) && out_ready_i) begin
        state_d  = FILL;
        result_d = '1;
        status_d = '0;
        ext_d    = 1'b1;
        mask_d   = '0;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
        lane_status_d = '0;
`endif
      end
      if (in_accept) begin
        result_d[lane_idx*DstWidth +: DstWidth] = result_i;
        status_d         = status_d | status_i;
        ext_d            = ext_d & extension_bit_i;
        mask_d[lane_idx] = 1'b1;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
        lane_status_d[lane_idx] = status_i;
`endif
        if (lane_idx == '0) tag_d = tag_i;
        if ((lane_idx == LastLane) || last_i) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          state_d = FILL;
          cnt_d   = lane_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      result_q <= '1;
      status_q <= '0;
      ext_q    <= 1'b1;
      tag_q    <= '0;
      mask_q   <= '0;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
      lane_status_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
      ext_q    <= ext_d;
      tag_q    <= tag_d;
      mask_q   <= mask_d;
`ifdef FPNEW_PACKER_LANE_STATUS_EN
      lane_status_q <= lane_status_d;
`endif
    end
  end

  assign result_o        = result_q;
  assign status_o        = status_q;
  assign extension_bit_o = ext_q;
  assign tag_o           = tag_q;
  assign lane_mask_o     = mask_q;
  assign out_valid_o     = (state_q == HOLD);
  assign busy_o          = (cnt_q != '0) | (state_q == HOLD);
`ifdef FPNEW_PACKER_LANE_STATUS_EN
  assign lane_status_o   = lane_status_q;
`endif

endmodule
